biquad_coefbank: RTL
====================

BIQUAD_COEFBANK -- requirements
Module: biquad_coefbank

Interface
REQ-001 SHALL have parameter NSECT, default 2, number of cascaded biquad sections (1..8).
REQ-002 SHALL have parameter COEFW, default 16, stored coefficient width (8..16).
REQ-003 SHALL have parameter DATAWIDTH, default 12, filter sample width.
REQ-004 SHALL have parameter BASEADDR, default 32'h3000_0000, byte base of register window.
REQ-005 SHALL have port clk_i  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have ports cyc_i, stb_i, we_i  input  1 each  Wishbone classic cycle, strobe, write-enable.
REQ-008 SHALL have port adr_i  input  32  Wishbone byte address.
REQ-009 SHALL have port dat_i  input  32  Wishbone write data.
REQ-010 SHALL have port dat_o  output  32  Wishbone read data, registered.
REQ-011 SHALL have port ack_o  output  1  Wishbone acknowledge, registered.
REQ-012 SHALL have port sample_stb_i  input  1  one-cycle pulse marking a filter sample boundary.
REQ-013 SHALL have ports x_i, y_i  input  DATAWIDTH each  filter input and output samples, two's complement.
REQ-014 SHALL have port coef_o  output  NSECT*5*COEFW  active coefficients; section s, index k at slice (s*5+k)*COEFW; k: 0=a11,1=a12,2=b10,3=b11,4=b12.
REQ-015 SHALL have port commit_pend_o  output  1  commit requested, not yet applied.

Function
REQ-016 Word offset SHALL be (adr_i-BASEADDR)>>2; adr_i[1:0] ignored; coefficient s,k at offset s*8+k; CTRL 0x40; XCAP 0x41; YCAP 0x42; SCNT 0x43.
REQ-017 Request SHALL be cyc_i&stb_i&~ack_o at an edge; ack_o SHALL be high the following cycle only, giving one wait state; back-to-back requests ack every second cycle.
REQ-018 ack_o SHALL be forced low in any cycle with cyc_i low.
REQ-019 Write SHALL take effect at the request edge; dat_o SHALL be captured at the request edge and hold until the next request.
REQ-020 Coefficient writes SHALL update the shadow register only, storing dat_i[15:16-COEFW].
REQ-021 Coefficient reads SHALL return the shadow value left-aligned in bits 15:0 (low bits zero), sign-extended into bits 31:16.
REQ-022 Write to CTRL with dat_i[0]=1 SHALL set commit pending; dat_i[0]=0 SHALL have no effect; CTRL read returns {31'b0, pending}.
REQ-023 On sample_stb_i with pending already set, all NSECT*5 active registers SHALL load their shadows in that edge and pending SHALL clear.
REQ-024 Commit write coincident with sample_stb_i SHALL set pending; transfer occurs at the next sample_stb_i.
REQ-025 Shadow write coincident with transfer: active SHALL receive the pre-write shadow; shadow takes new value.
REQ-026 On sample_stb_i, XCAP/YCAP SHALL capture x_i/y_i; SCNT SHALL increment, wrapping 32'hFFFF_FFFF to 0.
REQ-027 XCAP/YCAP reads SHALL return the value sign-extended to 32 bits; SCNT read returns the counter; all three read-only.
REQ-028 Addresses outside window, offsets with k>4, s>=NSECT, or unmapped SHALL be acked, read 0, writes ignored.
REQ-029 commit_pend_o SHALL equal the pending flag.

Reset
REQ-030 rst_i high at an edge SHALL clear shadow, active, pending, XCAP, YCAP, SCNT, dat_o and ack_o to 0, overriding any coincident request or sample_stb_i.
REQ-031 Reset mid-transaction SHALL drop ack_o; the bus master retries.

Structure
REQ-032 Package biquad_coef_pkg SHALL hold offsets (CTRL, XCAP, YCAP, SCNT), section stride 8, coefficient index constants 0..4.
REQ-033 Sub-module biquad_coef_section SHALL hold one section's five shadow/active pairs, instantiated NSECT times.

Verification
REQ-034 Write 0x4000 to sect0 a11, read back -> 0x0000_4000; coef_o slice unchanged (0).
REQ-035 Write CTRL=1, no strobe 10 cycles -> commit_pend_o=1, coef_o 0; pulse sample_stb_i -> slice=0x4000 next cycle, pend=0.
REQ-036 COEFW=12: write 0x8FFF to sect1 b12 -> read 0xFFFF_8FF0; active slice 12'h8FF after commit.
REQ-037 Commit write and sample_stb_i same edge -> pend=1, coef_o unchanged until the second strobe.
REQ-038 x_i=12'hFFE, three strobes -> XCAP read 0xFFFF_FFFE, SCNT read 3; rst_i -> SCNT 0.
REQ-039 Read offset 0x05 and adr_i=BASEADDR+0x400 -> ack one cycle after request, data 0, no state change.

Source files
------------

// File: rtl/biquad_coef_pkg.sv
// Shared register map, coefficient indices and address decode for the
// biquad coefficient bank.
package biquad_coef_pkg;

    localparam int NCOEF       = 5;
    localparam int IDX_A11     = 0;
    localparam int IDX_A12     = 1;
    localparam int IDX_B10     = 2;
    localparam int IDX_B11     = 3;
    localparam int IDX_B12     = 4;

    localparam int SECT_STRIDE = 8;
    localparam int SECT_SHIFT  = $clog2(SECT_STRIDE);

    localparam int OFF_CTRL    = 'h40;
    localparam int OFF_XCAP    = 'h41;
    localparam int OFF_YCAP    = 'h42;
    localparam int OFF_SCNT    = 'h43;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_COEF,
        SEL_CTRL,
        SEL_XCAP,
        SEL_YCAP,
        SEL_SCNT
    } reg_sel_e;

    function automatic logic is_coef_idx(input logic [SECT_SHIFT-1:0] idx);
        return (idx == SECT_SHIFT'(IDX_A11)) || (idx == SECT_SHIFT'(IDX_A12)) ||
               (idx == SECT_SHIFT'(IDX_B10)) || (idx == SECT_SHIFT'(IDX_B11)) ||
               (idx == SECT_SHIFT'(IDX_B12));
    endfunction

    // Anything that is not an exact match falls to SEL_NONE and reads as zero.
    function automatic reg_sel_e decode_sel(input logic [29:0] word, input int nsect);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (word == 30'(OFF_CTRL))
            sel = SEL_CTRL;
        else if (word == 30'(OFF_XCAP))
            sel = SEL_XCAP;
        else if (word == 30'(OFF_YCAP))
            sel = SEL_YCAP;
        else if (word == 30'(OFF_SCNT))
            sel = SEL_SCNT;
        else if ((int'(word[29:SECT_SHIFT]) < nsect) && is_coef_idx(word[SECT_SHIFT-1:0]))
            sel = SEL_COEF;
        return sel;
    endfunction

endpackage

// File: rtl/biquad_coef_section.sv
// One biquad section: five shadow coefficients written from the bus and
// five active coefficients loaded from the shadows on a commit.
module biquad_coef_section
    import biquad_coef_pkg::*;
#(
    parameter int COEFW = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        wr_en,
    input  logic [SECT_SHIFT-1:0]       wr_idx,
    input  logic [COEFW-1:0]            wr_data,
    input  logic                        load,
    output logic [NCOEF*COEFW-1:0]      shadow,
    output logic [NCOEF*COEFW-1:0]      active
);

    // Non-blocking update lets a coincident load see the pre-write shadow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (load)
                active <= shadow;
            for (int k = 0; k < NCOEF; k++) begin
                if (wr_en && (wr_idx == SECT_SHIFT'(k)))
                    shadow[k*COEFW +: COEFW] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/biquad_coefbank.sv
// Wishbone-mapped coefficient bank for a cascade of biquad sections with
// double-buffered commit on sample boundaries plus sample capture/counting.
module biquad_coefbank
    import biquad_coef_pkg::*;
#(
    parameter int          NSECT     = 2,
    parameter int          COEFW     = 16,
    parameter int          DATAWIDTH = 12,
    parameter logic [31:0] BASEADDR  = 32'h3000_0000
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cyc_i,
    input  logic                          stb_i,
    input  logic                          we_i,
    input  logic [31:0]                   adr_i,
    input  logic [31:0]                   dat_i,
    output logic [31:0]                   dat_o,
    output logic                          ack_o,
    input  logic                          sample_stb_i,
    input  logic [DATAWIDTH-1:0]          x_i,
    input  logic [DATAWIDTH-1:0]          y_i,
    output logic [NSECT*NCOEF*COEFW-1:0]  coef_o,
    output logic                          commit_pend_o
);

    localparam int SIW = 30 - SECT_SHIFT;

    logic                          ack_r;
    logic                          req;
    logic [31:0]                   adr_diff;
    logic [29:0]                   word;
    logic [SIW-1:0]                sect_idx;
    logic [SECT_SHIFT-1:0]         coef_idx;
    reg_sel_e                      sel;
    logic                          wr_coef;
    logic                          wr_commit;
    logic                          load;
    logic                          pending;
    logic [COEFW-1:0]              wr_data;
    logic [NSECT*NCOEF*COEFW-1:0]  shadow_all;
    logic [COEFW-1:0]              coef_sel;
    logic [15:0]                   coef_left;
    logic [31:0]                   rd_data;
    logic [DATAWIDTH-1:0]          xcap;
    logic [DATAWIDTH-1:0]          ycap;
    logic [31:0]                   scnt;
    logic                          unused_bits;

    // The registered ack is gated by cyc so an abandoned cycle never sees ack.
    assign ack_o         = ack_r & cyc_i;
    assign req           = cyc_i & stb_i & ~ack_o;
    assign adr_diff      = adr_i - BASEADDR;
    assign word          = adr_diff[31:2];
    assign sect_idx      = word[29:SECT_SHIFT];
    assign coef_idx      = word[SECT_SHIFT-1:0];
    assign sel           = decode_sel(word, NSECT);
    assign wr_coef       = req & we_i & (sel == SEL_COEF);
    assign wr_commit     = req & we_i & (sel == SEL_CTRL) & dat_i[0];
    assign load          = sample_stb_i & pending;
    assign wr_data       = dat_i[15 -: COEFW];
    assign commit_pend_o = pending;
    assign unused_bits   = ^{adr_diff[1:0], dat_i};

    for (genvar s = 0; s < NSECT; s++) begin : g_sect
        logic wr_en;
        assign wr_en = wr_coef && (sect_idx == SIW'(s));

        biquad_coef_section #(
            .COEFW (COEFW)
        ) u_sect (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .wr_en   (wr_en),
            .wr_idx  (coef_idx),
            .wr_data (wr_data),
            .load    (load),
            .shadow  (shadow_all[s*NCOEF*COEFW +: NCOEF*COEFW]),
            .active  (coef_o[s*NCOEF*COEFW +: NCOEF*COEFW])
        );
    end

    // Coefficients read back left-aligned in 16 bits, then sign-extended.
    always_comb begin
        coef_sel = '0;
        for (int s = 0; s < NSECT; s++) begin
            for (int k = 0; k < NCOEF; k++) begin
                if ((sect_idx == SIW'(s)) && (coef_idx == SECT_SHIFT'(k)))
                    coef_sel = shadow_all[(s*NCOEF+k)*COEFW +: COEFW];
            end
        end
        coef_left = 16'(coef_sel) << (16 - COEFW);

        rd_data = '0;
        case (sel)
            SEL_COEF: rd_data = {{16{coef_left[15]}}, coef_left};
            SEL_CTRL: rd_data = {31'b0, pending};
            SEL_XCAP: rd_data = 32'($signed(xcap));
            SEL_YCAP: rd_data = 32'($signed(ycap));
            SEL_SCNT: rd_data = scnt;
            default:  rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_r   <= 1'b0;
            dat_o   <= '0;
            pending <= 1'b0;
            xcap    <= '0;
            ycap    <= '0;
            scnt    <= '0;
        end else begin
            ack_r <= req;
            if (req)
                dat_o <= rd_data;
            // A fresh commit wins over the clear, so it survives a coincident strobe.
            if (wr_commit)
                pending <= 1'b1;
            else if (load)
                pending <= 1'b0;
            if (sample_stb_i) begin
                xcap <= x_i;
                ycap <= y_i;
                scnt <= scnt + 32'd1;
            end
        end
    end

endmodule
